// File: rtl/regfile_np.sv
// Register file: NREAD combinational read ports, one write port, hardwired-zero r0,
// per-register pending bits and a post-reset clear sequence. Optional macro: REGFILE_BYPASS_EN.
module regfile_np #(
  parameter  int WIDTH = 16,
  parameter  int DEPTH = 32,
  parameter  int NREAD = 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   reset_n,
  output logic                   ready,
  input  logic [NREAD-1:0]       rd_en,
  input  logic [NREAD*AW-1:0]    rd_addr,
  output logic [NREAD*WIDTH-1:0] rd_data,
  output logic [NREAD-1:0]       rd_pend,
  input  logic                   wr_en,
  input  logic [AW-1:0]          wr_addr,
  input  logic [WIDTH-1:0]       wr_data,
  input  logic                   rsv_en,
  input  logic [AW-1:0]          rsv_addr
);

  typedef enum logic {CLEAR = 1'b0, RUN = 1'b1} state_t;

  state_t            state_q, state_d;
  logic [AW-1:0]     clr_ptr_q, clr_ptr_d;
  logic              ready_q, ready_d;
  logic [WIDTH-1:0]  mem_q [DEPTH];
  logic [WIDTH-1:0]  mem_d [DEPTH];
  logic [DEPTH-1:0]  pend_q, pend_d;

  // Next-state for the clear sequencer and the storage/pending arrays
  always_comb begin
    state_d   = state_q;
    clr_ptr_d = clr_ptr_q;
    ready_d   = ready_q;
    mem_d     = mem_q;
    pend_d    = pend_q;
    if (reset_n) begin
      case (state_q)
        CLEAR: begin
          mem_d[clr_ptr_q]  = '0;
          pend_d[clr_ptr_q] = 1'b0;
          // pointer parks at DEPTH-1 so it never wraps back into the file
          if (clr_ptr_q == AW'(DEPTH - 1)) begin
            state_d = RUN;
            ready_d = 1'b1;
          end else begin
            clr_ptr_d = clr_ptr_q + AW'(1);
          end
        end
        RUN: begin
          if (wr_en && (wr_addr != '0)) begin
            mem_d[wr_addr]  = wr_data;
            pend_d[wr_addr] = 1'b0;
          end else begin
            pend_d = pend_q;
          end
          // reservation is applied after the write: a new producer wins
          if (rsv_en && (rsv_addr != '0)) begin
            pend_d[rsv_addr] = 1'b1;
          end else begin
            ready_d = ready_q;
          end
        end
        default: begin
          state_d   = CLEAR;
          clr_ptr_d = AW'(1);
          ready_d   = 1'b0;
        end
      endcase
    end else begin
      state_d = CLEAR;
    end
    mem_d[0]  = '0;
    pend_d[0] = 1'b0;
  end

  // Sequencer registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q   <= CLEAR;
      clr_ptr_q <= AW'(1);
      ready_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      clr_ptr_q <= clr_ptr_d;
      ready_q   <= ready_d;
    end
  end

  // Storage and pending bits are initialised by the clear sequence, not by reset
  always_ff @(posedge clk) begin
    mem_q  <= mem_d;
    pend_q <= pend_d;
  end

  // Combinational read ports, gated by ready and rd_en
  always_comb begin
    rd_data = '0;
    rd_pend = '0;
    for (int i = 0; i < NREAD; i++) begin
      if (ready_q && rd_en[i] && (rd_addr[i*AW +: AW] != '0)) begin
        rd_data[i*WIDTH +: WIDTH] = mem_q[rd_addr[i*AW +: AW]];
        rd_pend[i]                = pend_q[rd_addr[i*AW +: AW]];
`ifdef REGFILE_BYPASS_EN
        if (wr_en && (wr_addr == rd_addr[i*AW +: AW])) begin
          rd_data[i*WIDTH +: WIDTH] = wr_data;
          rd_pend[i]                = rsv_en && (rsv_addr == wr_addr);
        end else begin
          rd_pend[i] = pend_q[rd_addr[i*AW +: AW]];
        end
`endif
      end else begin
        rd_pend[i] = 1'b0;
      end
    end
  end

  assign ready = ready_q;

endmodule
